// File: rtl/skid_pkg.sv
// skid_pkg: shared width helpers for stream buffering blocks
package skid_pkg;

    function automatic int clog2(input int n);
        int r = 0;
        for (int v = n - 1; v > 0; v >>= 1) r++;
        return r;
    endfunction

    function automatic int cnt_w(input int depth);
        return clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return depth > 1 ? clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/skid_ptr_ctr.sv
// skid_ptr_ctr: pointer into a DEPTH-entry ring, wrapping DEPTH-1 -> 0, with synchronous clear
module skid_ptr_ctr
    import skid_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= '0;
        else if (clr)
            ptr <= '0;
        else if (inc)
            ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end

endmodule

// File: rtl/skid_fifo.sv
// skid_fifo: DEPTH-entry elastic buffer between valid/ready endpoints with optional empty-bypass,
// flush and occupancy; i_ready_o depends only on registered state and flush_i.
module skid_fifo
    import skid_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2,
    parameter bit BYPASS = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush_i,
    input  logic                    i_valid_i,
    input  logic [DATA_W-1:0]       i_data_i,
    output logic                    i_ready_o,
    input  logic                    e_ready_i,
    output logic                    e_valid_o,
    output logic [DATA_W-1:0]       e_data_o,
    output logic [cnt_w(DEPTH)-1:0] count_o
);

    localparam int CNT_W = cnt_w(DEPTH);
    localparam int PTR_W = ptr_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              empty;
    logic              full;
    logic              byp;
    logic              push;
    logic              pop;
    logic              pass;
    logic              wr_en;
    logic              rd_en;

    // A pass-through word is both pushed and popped but never touches storage.
    always_comb begin
        empty     = count == '0;
        full      = count == CNT_W'(DEPTH);
        byp       = BYPASS && empty;
        i_ready_o = !full && !flush_i;
        e_valid_o = (byp ? i_valid_i : !empty) && !flush_i;
        e_data_o  = byp ? i_data_i : mem[rd_ptr];
        push      = i_valid_i && i_ready_o;
        pop       = e_valid_o && e_ready_i;
        pass      = byp && push && e_ready_i;
        wr_en     = push && !pass;
        rd_en     = pop && !pass;
        count_o   = count;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (flush_i)
            count <= '0;
        else if (wr_en != rd_en)
            count <= wr_en ? count + 1'b1 : count - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        else if (wr_en)
            mem[wr_ptr] <= i_data_i;
    end

    skid_ptr_ctr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr (
        .clk   (clk),
        .reset (reset),
        .clr   (flush_i),
        .inc   (wr_en),
        .ptr   (wr_ptr)
    );

    skid_ptr_ctr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd (
        .clk   (clk),
        .reset (reset),
        .clr   (flush_i),
        .inc   (rd_en),
        .ptr   (rd_ptr)
    );

endmodule

// File: tb/tb_skid_fifo.sv
// tb_skid_fifo: directed vector table plus hand sequences over four skid_fifo configurations
module tb_skid_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       iv = 1'b0;
    logic [7:0] id = 8'h00;
    logic       er = 1'b0;

    logic r4, v4, r2, v2, rb, vb, r3, v3;
    logic [7:0] d4, d2, db, d3;
    logic [2:0] c4;
    logic [1:0] c2, cb, c3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    skid_fifo #(.DATA_W(8), .DEPTH(4), .BYPASS(1'b0)) u4 (
        .clk(clk), .reset(reset), .flush_i(flush), .i_valid_i(iv), .i_data_i(id),
        .i_ready_o(r4), .e_ready_i(er), .e_valid_o(v4), .e_data_o(d4), .count_o(c4));
    skid_fifo #(.DATA_W(8), .DEPTH(2), .BYPASS(1'b0)) u2 (
        .clk(clk), .reset(reset), .flush_i(flush), .i_valid_i(iv), .i_data_i(id),
        .i_ready_o(r2), .e_ready_i(er), .e_valid_o(v2), .e_data_o(d2), .count_o(c2));
    skid_fifo #(.DATA_W(8), .DEPTH(2), .BYPASS(1'b1)) ub (
        .clk(clk), .reset(reset), .flush_i(flush), .i_valid_i(iv), .i_data_i(id),
        .i_ready_o(rb), .e_ready_i(er), .e_valid_o(vb), .e_data_o(db), .count_o(cb));
    skid_fifo #(.DATA_W(8), .DEPTH(3), .BYPASS(1'b1)) u3 (
        .clk(clk), .reset(reset), .flush_i(flush), .i_valid_i(iv), .i_data_i(id),
        .i_ready_o(r3), .e_ready_i(er), .e_valid_o(v3), .e_data_o(d3), .count_o(c3));

    typedef struct {
        logic       fl;
        logic       iv;
        logic [7:0] id;
        logic       er;
        logic       ir;
        logic       ev;
        logic [7:0] ed;
        logic [2:0] cnt;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t vec(input logic f, input logic v, input logic [7:0] d, input logic e,
                                 input logic xr, input logic xv, input logic [7:0] xd,
                                 input logic [2:0] xc);
        vec_t t;
        t.fl = f; t.iv = v; t.id = d; t.er = e;
        t.ir = xr; t.ev = xv; t.ed = xd; t.cnt = xc;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic f, input logic v, input logic [7:0] d, input logic e);
        flush = f; iv = v; id = d; er = e;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Fill/drain at DEPTH=4 followed by a flush with handshakes requested
        tbl[0]  = vec(1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
        tbl[1]  = vec(1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 3'd1);
        tbl[2]  = vec(1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11, 3'd2);
        tbl[3]  = vec(1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 8'h11, 3'd3);
        tbl[4]  = vec(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h11, 3'd4);
        tbl[5]  = vec(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11, 3'd4);
        tbl[6]  = vec(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 3'd3);
        tbl[7]  = vec(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 3'd2);
        tbl[8]  = vec(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44, 3'd1);
        tbl[9]  = vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
        tbl[10] = vec(1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
        tbl[11] = vec(1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 8'hA1, 3'd1);
        tbl[12] = vec(1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 8'hA1, 3'd2);
        tbl[13] = vec(1'b1, 1'b1, 8'hA4, 1'b1, 1'b0, 1'b0, 8'h00, 3'd3);
        tbl[14] = vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
        tbl[15] = vec(1'b0, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0);
        tbl[16] = vec(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hB1, 3'd1);
        tbl[17] = vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);

        @(negedge clk);
        #2;
        chk("rst_ready", 32'(r4), 32'd1);
        chk("rst_valid", 32'(v4), 32'd0);
        chk("rst_data", 32'(d4), 32'd0);
        chk("rst_count", 32'(c4), 32'd0);
        do_reset();

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].fl, tbl[i].iv, tbl[i].id, tbl[i].er);
            #2;
            chk($sformatf("tbl%0d_ready", i), 32'(r4), 32'(tbl[i].ir));
            chk($sformatf("tbl%0d_valid", i), 32'(v4), 32'(tbl[i].ev));
            if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), 32'(d4), 32'(tbl[i].ed));
            chk($sformatf("tbl%0d_count", i), 32'(c4), 32'(tbl[i].cnt));
            cycle();
        end

        // Streaming at DEPTH=2: one cycle latency then one word per cycle
        do_reset();
        for (int k = 0; k < 100; k++) begin
            drive(1'b0, 1'b1, 8'(k), 1'b1);
            #2;
            chk("stream_ready", 32'(r2), 32'd1);
            chk("stream_valid", 32'(v2), k == 0 ? 32'd0 : 32'd1);
            chk("stream_count", 32'(c2), k == 0 ? 32'd0 : 32'd1);
            if (k != 0) chk($sformatf("stream_data%0d", k), 32'(d2), 32'(8'(k - 1)));
            cycle();
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        #2;
        chk("stream_last", 32'(d2), 32'h63);
        cycle();
        #2;
        chk("stream_empty_valid", 32'(v2), 32'd0);
        chk("stream_empty_count", 32'(c2), 32'd0);

        // Bypass at DEPTH=2
        do_reset();
        drive(1'b0, 1'b1, 8'hA5, 1'b1);
        #2;
        chk("byp_valid", 32'(vb), 32'd1);
        chk("byp_data", 32'(db), 32'hA5);
        chk("byp_count", 32'(cb), 32'd0);
        cycle();
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        #2;
        chk("byp_not_stored_count", 32'(cb), 32'd0);
        chk("byp_not_stored_valid", 32'(vb), 32'd0);
        cycle();
        drive(1'b0, 1'b1, 8'hA5, 1'b0);
        #2;
        chk("byp_stall_valid", 32'(vb), 32'd1);
        cycle();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        #2;
        chk("byp_stored_count", 32'(cb), 32'd1);
        chk("byp_stored_data", 32'(db), 32'hA5);
        cycle();
        #2;
        chk("byp_hold_valid", 32'(vb), 32'd1);
        chk("byp_hold_data", 32'(db), 32'hA5);
        er = 1'b1;
        cycle();
        #2;
        chk("byp_drained_count", 32'(cb), 32'd0);
        chk("byp_drained_valid", 32'(vb), 32'd0);

        // Ordering with bypass at DEPTH=3
        do_reset();
        drive(1'b0, 1'b1, 8'h01, 1'b0);
        #2;
        chk("ord_first_data", 32'(d3), 32'h01);
        cycle();
        drive(1'b0, 1'b1, 8'h02, 1'b1);
        #2;
        chk("ord_stored_first", 32'(d3), 32'h01);
        chk("ord_count1", 32'(c3), 32'd1);
        chk("ord_ready", 32'(r3), 32'd1);
        cycle();
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        #2;
        chk("ord_second_valid", 32'(v3), 32'd1);
        chk("ord_second_data", 32'(d3), 32'h02);
        chk("ord_count2", 32'(c3), 32'd1);
        cycle();
        #2;
        chk("ord_empty_count", 32'(c3), 32'd0);
        chk("ord_empty_valid", 32'(v3), 32'd0);

        // Pointer wrap at DEPTH=3 then async reset while full
        do_reset();
        drive(1'b0, 1'b1, 8'h10, 1'b0);
        cycle();
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b1, 8'(8'h11 + k), 1'b1);
            #2;
            chk($sformatf("wrap_data%0d", k), 32'(d3), 32'(8'(8'h10 + k)));
            chk("wrap_count", 32'(c3), 32'd1);
            cycle();
        end
        drive(1'b0, 1'b1, 8'hC1, 1'b0);
        cycle();
        drive(1'b0, 1'b1, 8'hC2, 1'b0);
        #2;
        chk("fill_count2", 32'(c3), 32'd2);
        cycle();
        drive(1'b0, 1'b1, 8'hC3, 1'b0);
        #2;
        chk("full_ready", 32'(r3), 32'd0);
        chk("full_count", 32'(c3), 32'd3);
        chk("full_head", 32'(d3), 32'h1A);
        #1;
        reset = 1'b1;
        id = 8'h77;
        #1;
        chk("arst_count", 32'(c3), 32'd0);
        chk("arst_ready", 32'(r3), 32'd1);
        chk("arst_valid", 32'(v3), 32'd1);
        chk("arst_data", 32'(d3), 32'h77);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b1, 8'h5C, 1'b0);
        cycle();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        #2;
        chk("post_rst_count", 32'(c3), 32'd1);
        chk("post_rst_first", 32'(d3), 32'h5C);
        er = 1'b1;
        cycle();
        #2;
        chk("post_rst_drained", 32'(c3), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
